// File: rtl/fetch_ir_ctrl.sv
// Fetch sequencer feeding the decode IR: issues imem reads, buffers a word during decode stall,
// squashes in-flight reads on redirect. Outputs are combinational from state and inputs.
module fetch_ir_ctrl #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              imem_resp,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              imem_read,
    output logic              pc_load,
    output logic              ir_load,
    output logic              ir_keep,
    output logic              ir_flush,
    output logic [WORD_W-1:0] ir_word,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        imem_read = 1'b0;
        pc_load   = 1'b0;
        ir_load   = 1'b0;
        ir_word   = imem_rdata;

        case (state_q)
            FETCH: begin
                imem_read = 1'b1;
                if (imem_resp) begin
                    // A response coinciding with a redirect is simply dropped.
                    if (!flush) begin
                        pc_load = 1'b1;
                        if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            ir_load = 1'b1;
                        end
                    end
                end else if (flush) begin
                    state_d = SQUASH;
                end
            end
            HOLD: begin
                ir_word = buf_q;
                if (flush) begin
                    state_d = FETCH;
                end else if (!stall) begin
                    ir_load = 1'b1;
                    state_d = FETCH;
                end
            end
            SQUASH: begin
                // Outstanding read must drain before a new one is issued.
                imem_read = 1'b1;
                if (imem_resp) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        ir_flush  = flush;
        ir_keep   = stall & ~flush & ~ir_load;
        stall_cnt = cnt_q;
        cnt_d     = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

        if (reset) begin
            imem_read = 1'b0;
            pc_load   = 1'b0;
            ir_load   = 1'b0;
            ir_keep   = 1'b0;
            ir_flush  = 1'b0;
            ir_word   = '0;
            stall_cnt = '0;
        end
    end

endmodule
